ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 2, number of cycles a strobe is held per access (legal range 1..15).
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
REQ-005 SHALL have the following requester-side ports:
  req     in   2           request per requester, bit i = requester i
  req_we  in   2           1 = write, 0 = read, per requester
  addr0   in   ADDR_WIDTH  requester 0 address
  addr1   in   ADDR_WIDTH  requester 1 address
  wdata0  in   DATA_WIDTH  requester 0 write data
  wdata1  in   DATA_WIDTH  requester 1 write data
  ack     out  2           one-cycle completion pulse per requester
  rdata   out  DATA_WIDTH  read data, valid when ack pulses for a read
  busy    out  1           high in any state other than IDLE
REQ-006 SHALL have the following memory-side ports:
  mem_we     out  1           write enable to RAM
  mem_oe     out  1           output enable to RAM
  mem_addr   out  ADDR_WIDTH  address to RAM
  mem_wdata  out  DATA_WIDTH  data driven to RAM
  mem_rdata  in   DATA_WIDTH  data returned from RAM

Function
REQ-007 SHALL implement the states IDLE, ACCESS and DONE.
REQ-008 IDLE: if any req bit is high at a rising edge, SHALL latch the winner index, its req_we, its address and its write data, then go to ACCESS; otherwise SHALL stay in IDLE.
REQ-009 Arbitration SHALL be round-robin: a lone requester always wins; when both request, the winner is the one not granted last; after reset requester 0 has priority.
REQ-010 ACCESS SHALL last exactly ACCESS_CYCLES cycles, counted by a 4-bit counter, then go to DONE.
REQ-011 In ACCESS, the latched address SHALL drive mem_addr and the latched data SHALL drive mem_wdata; mem_we = latched we and mem_oe = NOT latched we.
REQ-012 mem_we and mem_oe SHALL never both be high; both SHALL be 0 in IDLE and DONE.
REQ-013 On the last ACCESS edge of a read, SHALL capture mem_rdata into rdata; rdata SHALL hold its value until the next read completes and SHALL be unchanged by writes.
REQ-014 DONE SHALL last one cycle with ack[winner]=1 and the other ack bit 0, then go to IDLE; ack SHALL be 0 in all other states.
REQ-015 Latency: a request seen in IDLE at cycle 0 SHALL produce ack in cycle ACCESS_CYCLES+1; minimum spacing between grants SHALL be ACCESS_CYCLES+2 cycles.
REQ-016 Requesters SHALL hold req, addr, wdata and req_we until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-017 Dropping req during ACCESS SHALL NOT abort the transaction: it completes and ack still pulses.
REQ-018 Changing addrN, wdataN or req_we after the grant SHALL NOT affect the memory-side outputs of the transaction in progress.
REQ-019 The last-grant pointer SHALL update only on entry to ACCESS.

Reset
REQ-020 While rst=1, SHALL force state=IDLE, counter=0, ack=0, busy=0, mem_we=0, mem_oe=0, mem_addr=0, mem_wdata=0, rdata=0 and last-grant pointer = requester 1 (so requester 0 wins first), asynchronously.
REQ-021 Reset asserted mid-ACCESS SHALL drop the strobes immediately; no ack SHALL pulse for the aborted transaction.

Verification
REQ-022 Single write (ACCESS_CYCLES=2): req=01, req_we=01, addr0=0x05, wdata0=0xA5 -> mem_we=1, mem_addr=0x05 and mem_wdata=0xA5 in cycles 1-2; ack=01 in cycle 3.
REQ-023 Read back: req=10, req_we=00, addr1=0x05, mem_rdata=0xA5 -> mem_oe=1 in cycles 1-2; ack=10 and rdata=0xA5 in cycle 3.
REQ-024 Contention: req=11 held continuously from reset -> grants alternate 0,1,0,1; acks in cycles 3, 7, 11 and 15.
REQ-025 Abort: rst=1 during the second ACCESS cycle of a write -> mem_we=0 immediately, no ack, busy=0; after release req=10 is granted normally.
REQ-026 Robustness: req dropped and addr0 changed to 0x7F during ACCESS -> mem_addr stays 0x05, ack still pulses; mem_we and mem_oe are never both 1 (checked by assertion throughout).

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port RAM.
// Ports: clk, rst (async, active high);
//        requester side: req[1:0], req_we[1:0], addr0/addr1, wdata0/wdata1,
//                        ack[1:0], rdata, busy;
//        memory side:    mem_we, mem_oe, mem_addr, mem_wdata, mem_rdata.
module ram_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  win, last, we_l, nxt, access;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;
  // Under contention the requester not granted last wins; a lone requester always wins.
  assign nxt = (req == 2'b11) ? ~last : req[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      win     <= 1'b0;
      last    <= 1'b1;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata   <= '0;
    end else
      case (state)
        IDLE:
          if (|req) begin
            state   <= ACCESS;
            cnt     <= '0;
            win     <= nxt;
            last    <= nxt;
            we_l    <= req_we[nxt];
            addr_l  <= nxt ? addr1 : addr0;
            wdata_l <= nxt ? wdata1 : wdata0;
          end
        ACCESS:
          if (cnt == LAST_CNT) begin
            state <= DONE;
            cnt   <= '0;
            if (!we_l) rdata <= mem_rdata;
          end else
            cnt <= cnt + 4'd1;
        default:
          state <= IDLE;
      endcase
  // Memory-side outputs are decoded from registered state so reset clears them at once.
  assign access    = state == ACCESS;
  assign mem_we    = access & we_l;
  assign mem_oe    = access & ~we_l;
  assign mem_addr  = access ? addr_l : '0;
  assign mem_wdata = access ? wdata_l : '0;
  assign ack       = (state == DONE) ? {win, ~win} : 2'b00;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
  localparam int AC = 2;
  logic       clk = 0, rst = 1;
  logic [1:0] req = 0, req_we = 0, ack;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic       busy, mem_we, mem_oe;
  int         checks = 0, failures = 0;
  logic       m_last = 1;
  logic [7:0] m_rdata = 0;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (mem_we && mem_oe) begin
      failures++;
      $display("FAIL strobe_exclusive: mem_we=%b mem_oe=%b required not both 1", mem_we, mem_oe);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    checks++;
    if ({ack, busy, mem_we, mem_oe, mem_addr, mem_wdata, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b busy=%b we=%b oe=%b addr=%h wdata=%h rdata=%h required all 0",
               ack, busy, mem_we, mem_oe, mem_addr, mem_wdata, rdata);
    end
    m_last = 1;
    m_rdata = 0;
    rst = 0;
    step();
  endtask

  // One complete transaction from IDLE: drive, then check every cycle up to ack and return to IDLE.
  task automatic do_txn(input logic [1:0] r, input logic [1:0] we, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] mr, input bit perturb);
    logic w;
    logic [7:0] ea, ed;
    logic ewe;
    w   = (r == 2'b11) ? !m_last : r[1];
    m_last = w;
    ewe = we[w];
    ea  = w ? a1 : a0;
    ed  = w ? d1 : d0;
    req = r; req_we = we; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; mem_rdata = mr;
    for (int c = 1; c <= AC; c++) begin
      step();
      if (perturb && c == 1) begin
        req = 0; addr0 = 8'h7F; addr1 = ~a1; wdata0 = ~d0; wdata1 = ~d1; req_we = ~we;
      end
      checks++;
      if (mem_we !== ewe || mem_oe !== !ewe || mem_addr !== ea || (ewe && mem_wdata !== ed) || busy !== 1 || ack !== 0) begin
        failures++;
        $display("FAIL access_c%0d: we=%b oe=%b addr=%h wdata=%h busy=%b ack=%b required we=%b addr=%h wdata=%h busy=1 ack=00",
                 c, mem_we, mem_oe, mem_addr, mem_wdata, busy, ack, ewe, ea, ed);
      end
    end
    if (!ewe) m_rdata = mr;
    step();
    checks++;
    if (ack !== (w ? 2'b10 : 2'b01) || rdata !== m_rdata || mem_we || mem_oe || busy !== 1) begin
      failures++;
      $display("FAIL done: ack=%b rdata=%h we=%b oe=%b busy=%b required ack=%b rdata=%h we=0 oe=0 busy=1",
               ack, rdata, mem_we, mem_oe, busy, w ? 2'b10 : 2'b01, m_rdata);
    end
    req = 0;
    step();
    checks++;
    if (ack !== 0 || busy !== 0 || rdata !== m_rdata) begin
      failures++;
      $display("FAIL idle_after: ack=%b busy=%b rdata=%h required ack=00 busy=0 rdata=%h", ack, busy, rdata, m_rdata);
    end
  endtask

  task automatic test_single_write();
    do_txn(2'b01, 2'b01, 8'h05, 8'h00, 8'hA5, 8'h00, 8'h3C, 0);
  endtask

  task automatic test_read_back();
    do_txn(2'b10, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00, 8'hA5, 0);
  endtask

  task automatic test_robust();
    do_txn(2'b01, 2'b01, 8'h05, 8'h11, 8'h5A, 8'h22, 8'h00, 1);
    do_txn(2'b01, 2'b00, 8'h05, 8'h11, 8'h5A, 8'h22, 8'hC3, 1);
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    rst = 1; req = 2'b11; req_we = 2'b00; mem_rdata = 8'h96;
    step();
    rst = 0;
    m_last = 1;
    m_rdata = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = (k % 4 == 3) ? (((k / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      if (k % 4 == 3) begin
        m_last = exp[1];
        m_rdata = 8'h96;
      end
      checks++;
      if (ack !== exp) begin
        failures++;
        $display("FAIL contention_k%0d: ack=%b required %b", k, ack, exp);
      end
    end
    req = 0;
    step();
  endtask

  task automatic test_abort();
    req = 2'b01; req_we = 2'b01; addr0 = 8'h33; wdata0 = 8'h44;
    step();
    step();
    rst = 1;
    #1;
    checks++;
    if (mem_we !== 0 || busy !== 0 || ack !== 0 || rdata !== 0) begin
      failures++;
      $display("FAIL abort_now: we=%b busy=%b ack=%b rdata=%h required 0 0 00 00", mem_we, busy, ack, rdata);
    end
    req = 0;
    m_last = 1;
    m_rdata = 0;
    step();
    step();
    checks++;
    if (ack !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL abort_noack: ack=%b busy=%b required 00 0", ack, busy);
    end
    rst = 0;
    step();
    do_txn(2'b10, 2'b00, 8'h00, 8'h21, 8'h00, 8'h00, 8'h5E, 0);
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      do_txn(r, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), bit'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    // req held across ack is a new request: second grant comes AC+2 cycles after the first.
    int t;
    logic w;
    req = 2'b11; req_we = 2'b11; addr0 = 8'h01; addr1 = 8'h02;
    w = !m_last;
    t = 0;
    while (ack === 0 && t < 20) begin step(); t++; end
    checks++;
    if (ack !== (w ? 2'b10 : 2'b01) || t != AC + 1) begin
      failures++;
      $display("FAIL b2b_first: ack=%b t=%0d required ack=%b t=%0d", ack, t, w ? 2'b10 : 2'b01, AC + 1);
    end
    step();
    t = 0;
    while (ack === 0 && t < 20) begin step(); t++; end
    checks++;
    if (ack !== (w ? 2'b01 : 2'b10) || t != AC + 1) begin
      failures++;
      $display("FAIL b2b_second: ack=%b t=%0d required ack=%b t=%0d", ack, t, w ? 2'b01 : 2'b10, AC + 1);
    end
    m_last = !w;
    req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_robust();
    test_contention();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
